// File: rtl/m10_stopwatch_ctrl.sv
// BCD stopwatch sequencer for a chain of external mod-10 digit counters.
// Generates the count tick, the ripple-free carry enables, a lap-freezable display and a sticky overflow flag.
//
// state | meaning
// CLR   | one-cycle clear of counters, prescaler, overflow and lap freeze
// IDLE  | cleared and waiting for start_stop
// RUN   | prescaler advancing, ticks enable the digit chain
// STOP  | paused, prescaler phase held for resume
module m10_stopwatch_ctrl #(
   parameter int NDIG     = 4,
   parameter int PRESCALE = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_stop,
   input  logic                clear,
   input  logic                lap,
   input  logic [4*NDIG-1:0]   digit_q,
   output logic [NDIG-1:0]     cnt_pause,
   output logic                cnt_clr,
   output logic [4*NDIG-1:0]   disp,
   output logic                running,
   output logic                lap_frozen,
   output logic                ovf
);

   localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   localparam logic [1:0] ST_CLR  = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_STOP = 2'd3;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [PW-1:0] pcnt;
   logic [PW-1:0] pcnt_nxt;
   logic          tick;
   logic          lap_toggle;
   logic [NDIG:0] carry;

   assign tick    = (state == ST_RUN) && (pcnt == PMAX);
   assign cnt_clr = (state == ST_CLR);

   // carry[i] means every digit below i reads 9 during a tick; carry[NDIG] is full overflow
   always_comb begin
      carry    = '0;
      carry[0] = tick;
      for (int i = 0; i < NDIG; i++) begin
         carry[i+1] = carry[i] && (digit_q[4*i +: 4] == 4'd9);
      end
   end

   assign cnt_pause = ~carry[NDIG-1:0];

   always_comb begin
      state_nxt = state;
      pcnt_nxt  = pcnt;
      case (state)
         ST_CLR: begin
            state_nxt = ST_IDLE;
            pcnt_nxt  = '0;
         end
         ST_IDLE: begin
            if (clear) begin
               state_nxt = ST_CLR;
            end else if (start_stop) begin
               state_nxt = ST_RUN;
               pcnt_nxt  = '0;
            end
         end
         ST_RUN: begin
            pcnt_nxt = (pcnt == PMAX) ? '0 : pcnt + PW'(1);
            if (clear) begin
               state_nxt = ST_CLR;
            end else if (start_stop) begin
               state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (clear) begin
               state_nxt = ST_CLR;
            end else if (start_stop) begin
               state_nxt = ST_RUN;
            end
         end
      endcase
   end

   // lap loses to clear and start_stop arriving in the same cycle
   assign lap_toggle = lap && !clear && !start_stop &&
                       ((state == ST_RUN) || (state == ST_STOP));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_CLR;
         pcnt       <= '0;
         running    <= 1'b0;
         ovf        <= 1'b0;
         lap_frozen <= 1'b0;
         disp       <= '0;
      end else begin
         state   <= state_nxt;
         pcnt    <= pcnt_nxt;
         running <= (state_nxt == ST_RUN);
         if (state == ST_CLR) begin
            ovf        <= 1'b0;
            lap_frozen <= 1'b0;
         end else begin
            if (carry[NDIG]) begin
               ovf <= 1'b1;
            end
            if (lap_toggle) begin
               lap_frozen <= ~lap_frozen;
            end
         end
         if (!lap_frozen) begin
            disp <= digit_q;
         end
      end
   end

endmodule

// File: tb/tb_m10_stopwatch_ctrl.sv
// Bench for m10_stopwatch_ctrl: behavioural digit chain plus a tick scoreboard
// checked by an independent monitor, and directed checks of the status outputs.
module tb_m10_stopwatch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ss = 1'b0;
   logic        clr = 1'b0;
   logic        lp = 1'b0;
   logic [15:0] dq = '0;
   logic        load_en = 1'b0;
   logic [15:0] load_val = '0;
   logic [3:0]  cnt_pause;
   logic        cnt_clr;
   logic [15:0] disp;
   logic        running;
   logic        lap_frozen;
   logic        ovf;

   int cyc = 0;
   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      int         cyc;
      logic [3:0] pause;
   } exp_t;
   exp_t sb[$];

   m10_stopwatch_ctrl #(.NDIG(4), .PRESCALE(10)) dut (
      .clk(clk),
      .reset(rst),
      .start_stop(ss),
      .clear(clr),
      .lap(lp),
      .digit_q(dq),
      .cnt_pause(cnt_pause),
      .cnt_clr(cnt_clr),
      .disp(disp),
      .running(running),
      .lap_frozen(lap_frozen),
      .ovf(ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // behavioural m10_cnt chain with a bench-side preload
   always @(posedge clk) begin
      if (load_en) begin
         dq <= load_val;
      end else if (cnt_clr) begin
         dq <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (!cnt_pause[i]) dq[4*i +: 4] <= (dq[4*i +: 4] == 4'd9) ? 4'd0 : dq[4*i +: 4] + 4'd1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // monitor: any cycle with a pause bit low is a tick that must match the scoreboard head
   always @(negedge clk) begin
      if (rst && cnt_pause !== 4'hF) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL tick_unexpected at cyc %0d: got pause %b expected no tick", cyc, cnt_pause);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("tick_cyc", cyc, e.cyc);
            chk("tick_pause", {28'd0, cnt_pause}, {28'd0, e.pause});
         end
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic push(input int c, input logic [3:0] p);
      exp_t e;
      e.cyc   = c;
      e.pause = p;
      sb.push_back(e);
   endtask

   // drive a pulse so it is sampled at edge x
   task automatic pulse_at(input int x, input logic s, input logic c, input logic l);
      wait_until(x - 1);
      ss = s; clr = c; lp = l;
      @(negedge clk);
      ss = 1'b0; clr = 1'b0; lp = 1'b0;
   endtask

   task automatic load_at(input int x, input logic [15:0] v);
      wait_until(x - 1);
      load_en = 1'b1; load_val = v;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   int e0, s0, r0, c0, m0;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_cnt_clr", {31'd0, cnt_clr}, 32'd1);
      chk("rst_pause", {28'd0, cnt_pause}, 32'hF);
      chk("rst_disp", {16'd0, disp}, 32'd0);
      rst = 1'b1;
      #1;
      chk("clr_cycle", {31'd0, cnt_clr}, 32'd1);
      @(negedge clk);
      chk("idle_cnt_clr", {31'd0, cnt_clr}, 32'd0);
      chk("idle_running", {31'd0, running}, 32'd0);
      chk("idle_disp", {16'd0, disp}, 32'd0);

      // lap is ignored in IDLE
      pulse_at(cyc + 1, 1'b0, 1'b0, 1'b1);
      chk("idle_lap", {31'd0, lap_frozen}, 32'd0);

      // run: 12 ticks, digit0 wraps on the 10th
      e0 = cyc + 2;
      for (int k = 1; k <= 12; k++) push(e0 + 9 + 10*(k-1), (k == 10) ? 4'b1100 : 4'b1110);
      pulse_at(e0, 1'b1, 1'b0, 1'b0);
      chk("run_running", {31'd0, running}, 32'd1);
      wait_until(e0 + 15);
      chk("run_disp1", {16'd0, disp}, 32'h0001);

      // stop with pcnt=4, hold 50 cycles, resume
      s0 = e0 + 124;
      pulse_at(s0, 1'b1, 1'b0, 1'b0);
      chk("stop_running", {31'd0, running}, 32'd0);
      wait_until(s0 + 50);
      chk("stop_disp", {16'd0, disp}, 32'h0012);
      r0 = s0 + 51;
      push(r0 + 5, 4'b1110);
      push(r0 + 15, 4'b1110);
      push(r0 + 25, 4'b0000);
      pulse_at(r0, 1'b1, 1'b0, 1'b0);

      // lap freeze while counting
      load_at(r0 + 7, 16'h0037);
      pulse_at(r0 + 8, 1'b0, 1'b0, 1'b1);
      chk("lap_disp_cap", {16'd0, disp}, 32'h0037);
      chk("lap_frozen_set", {31'd0, lap_frozen}, 32'd1);
      wait_until(r0 + 17);
      chk("lap_disp_hold", {16'd0, disp}, 32'h0037);
      pulse_at(r0 + 18, 1'b0, 1'b0, 1'b1);
      chk("lap_frozen_clr", {31'd0, lap_frozen}, 32'd0);
      chk("lap_disp_lag", {16'd0, disp}, 32'h0037);
      @(negedge clk);
      chk("lap_disp_live", {16'd0, disp}, 32'h0038);

      // overflow from 9999
      load_at(r0 + 20, 16'h9999);
      wait_until(r0 + 25);
      chk("ovf_before", {31'd0, ovf}, 32'd0);
      wait_until(r0 + 27);
      chk("ovf_set", {31'd0, ovf}, 32'd1);
      pulse_at(r0 + 28, 1'b0, 1'b0, 1'b1);
      chk("ovf_disp_wrap", {16'd0, disp}, 32'h0000);
      chk("ovf_sticky", {31'd0, ovf}, 32'd1);
      chk("lap_frozen_pre", {31'd0, lap_frozen}, 32'd1);

      // clear + start_stop + lap together
      c0 = r0 + 30;
      pulse_at(c0, 1'b1, 1'b1, 1'b1);
      chk("sim_cnt_clr", {31'd0, cnt_clr}, 32'd1);
      chk("sim_running", {31'd0, running}, 32'd0);
      @(negedge clk);
      chk("sim_idle_clr", {31'd0, cnt_clr}, 32'd0);
      chk("sim_lap_frozen", {31'd0, lap_frozen}, 32'd0);
      chk("sim_ovf", {31'd0, ovf}, 32'd0);
      chk("sim_running2", {31'd0, running}, 32'd0);
      @(negedge clk);
      chk("sim_disp", {16'd0, disp}, 32'h0000);

      // reset asserted mid-run
      m0 = cyc + 2;
      pulse_at(m0, 1'b1, 1'b0, 1'b0);
      wait_until(m0 + 3);
      chk("mid_running", {31'd0, running}, 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_clr", {31'd0, cnt_clr}, 32'd1);
      chk("mid_rst_running", {31'd0, running}, 32'd0);
      chk("mid_rst_pause", {28'd0, cnt_pause}, 32'hF);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_clr_cycle", {31'd0, cnt_clr}, 32'd1);
      @(negedge clk);
      chk("mid_idle", {31'd0, cnt_clr}, 32'd0);
      chk("mid_idle_running", {31'd0, running}, 32'd0);
      repeat (15) @(negedge clk);

      while (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         n_vec++;
         n_bad++;
         $display("FAIL tick_missing: got no tick expected one at cyc %0d pause %b", e.cyc, e.pause);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
